// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle master: turns rising-edge command strobes into exactly one
// bus transaction each, buffering back-to-back commands in a small in-order queue.
module wb_cmd_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_stb,
  input  logic [7:0]  adr,
  input  logic [33:0] cmd_word,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        err,
  output logic        ovf,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t        state_q;
  logic          stb_q;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [40:0]   mem_q [DEPTH];
  logic [TW-1:0] tmo_q;
  logic          busy_q, done_q, err_q, ovf_q;
  logic [31:0]   rd_data_q;
  logic          cyc_q, we_q;
  logic [7:0]    wadr_q;
  logic [31:0]   wdat_q;
  logic [3:0]    sel_q;

  logic        accept, push, drop, pop, busy_d;
  logic [40:0] head;
  logic        unused_rsvd;

  assign unused_rsvd = cmd_word[33];

  // A full queue drops the new command even if an entry leaves in the same cycle.
  assign accept = cmd_stb & ~stb_q;
  assign push   = accept & (count_q != FULL);
  assign drop   = accept & (count_q == FULL);
  assign pop    = (state_q == S_IDLE) & (count_q != '0);
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + (AW+1)'(1);
    else if (!push && pop)
      count_d = count_q - (AW+1)'(1);
  end

  assign busy_d = (count_d != '0) | pop | (state_q == S_BUS);

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {adr, cmd_word[32:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      stb_q     <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      wadr_q    <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
    end else begin
      stb_q   <= cmd_stb;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= 1'b0;
      if (push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (drop)
        ovf_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            wadr_q   <= head[40:33];
            we_q     <= head[32];
            wdat_q   <= head[31:0];
            cyc_q    <= 1'b1;
            sel_q    <= 4'hF;
            tmo_q    <= '0;
            state_q  <= S_BUS;
          end
        end
        S_BUS: begin
          // err outranks ack; the timeout only fires when the slave stays silent.
          if (wb_err_i || wb_ack_i || (tmo_q == TLAST)) begin
            if (wb_err_i || !wb_ack_i)
              err_q <= 1'b1;
            else if (!we_q)
              rd_data_q <= wb_dat_i;
            cyc_q   <= 1'b0;
            sel_q   <= 4'h0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;
  assign ovf      = ovf_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = wadr_q;
  assign wb_dat_o = wdat_q;
  assign wb_sel_o = sel_q;

endmodule
